// File: rtl/evaluador_estado.sv
// evaluador_estado: filters the four need levels into the pet's displayed state,
// with tick-based persistence, a sleep toggle and sticky death. Optional macro: TEST_MODE_EN.
module evaluador_estado #(
    parameter int DIV          = 50_000_000,
    parameter int PERSIST      = 3,
    parameter int MUERTE_TICKS = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Nivel_Animo,
    input  logic [1:0] Nivel_Energia,
    input  logic [1:0] Nivel_Descanso,
    input  logic [1:0] Nivel_Medicina,
    input  logic       Entrada_Dormir,
`ifdef TEST_MODE_EN
    input  logic       Bot_Test,
`endif
    output logic [2:0] Estado,
    output logic       Cambio,
    output logic       Alerta
);

    typedef enum logic [2:0] {
        NEUTRO     = 3'd0,
        FELIZ      = 3'd1,
        HAMBRIENTO = 3'd2,
        CANSADO    = 3'd3,
        ENFERMO    = 3'd4,
        TRISTE     = 3'd5,
        DORMIDO    = 3'd6,
        MUERTO     = 3'd7
    } estado_t;

    localparam int PW = $clog2(DIV);
    localparam int HW = $clog2(PERSIST + 1);
    localparam int DW = $clog2(MUERTE_TICKS + 1);

    logic [PW-1:0] presc;
    logic          presc_wrap;
    logic          tick;
    logic [2:0]    zeros;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic [DW-1:0] death_cnt, death_nxt;
    estado_t       estado_q, estado_nxt, cand, last_cand, last_cand_nxt;

    assign presc_wrap = (presc == PW'(DIV - 1));

`ifdef TEST_MODE_EN
    assign tick = Bot_Test || presc_wrap;
`else
    assign tick = presc_wrap;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
        end
`ifdef TEST_MODE_EN
        else if (Bot_Test) begin
            presc <= '0;
        end
`endif
        else if (presc_wrap) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    assign zeros = {2'b00, Nivel_Animo    == 2'd0}
                 + {2'b00, Nivel_Energia  == 2'd0}
                 + {2'b00, Nivel_Descanso == 2'd0}
                 + {2'b00, Nivel_Medicina == 2'd0};

    // Most urgent need wins; FELIZ only when every level is comfortably high.
    always_comb begin
        cand = NEUTRO;
        if (Nivel_Medicina == 2'd0) begin
            cand = ENFERMO;
        end else if (Nivel_Energia == 2'd0) begin
            cand = HAMBRIENTO;
        end else if (Nivel_Descanso == 2'd0) begin
            cand = CANSADO;
        end else if (Nivel_Animo == 2'd0) begin
            cand = TRISTE;
        end else if (Nivel_Animo[1] && Nivel_Energia[1] && Nivel_Descanso[1] && Nivel_Medicina[1]) begin
            cand = FELIZ;
        end
    end

    always_comb begin
        estado_nxt    = estado_q;
        hold_nxt      = hold_cnt;
        last_cand_nxt = last_cand;
        death_nxt     = death_cnt;

        if (tick) begin
            if (zeros >= 3'd2) begin
                if (death_cnt != DW'(MUERTE_TICKS)) begin
                    death_nxt = death_cnt + 1'b1;
                end
            end else begin
                death_nxt = '0;
            end
        end

        // Candidate tracking is frozen while asleep or dead.
        if (tick && estado_q != DORMIDO && estado_q != MUERTO) begin
            if (cand == last_cand) begin
                if (hold_cnt != HW'(PERSIST)) begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end else begin
                hold_nxt      = HW'(1);
                last_cand_nxt = cand;
            end
        end

        if (estado_q != MUERTO) begin
            if (tick && death_nxt == DW'(MUERTE_TICKS)) begin
                estado_nxt = MUERTO;
            end else if (estado_q == DORMIDO) begin
                if (Entrada_Dormir || (tick && Nivel_Descanso == 2'd3)) begin
                    estado_nxt = cand;
                    hold_nxt   = '0;
                end
            end else if (Entrada_Dormir) begin
                estado_nxt = DORMIDO;
            end else if (tick && hold_nxt == HW'(PERSIST) && cand != estado_q) begin
                estado_nxt = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q  <= NEUTRO;
            last_cand <= NEUTRO;
            hold_cnt  <= '0;
            death_cnt <= '0;
            Cambio    <= 1'b0;
            Alerta    <= 1'b0;
        end else begin
            estado_q  <= estado_nxt;
            last_cand <= last_cand_nxt;
            hold_cnt  <= hold_nxt;
            death_cnt <= death_nxt;
            Cambio    <= (estado_nxt != estado_q);
            Alerta    <= (zeros != 3'd0);
        end
    end

    assign Estado = estado_q;

endmodule
